// File: rtl/wt_l15_store_splitter_pkg.sv
// Shared types and helpers for the L1.5 store splitter.
//   - MEM_TID_WIDTH     : default transaction ID width
//   - split_state_e     : splitter FSM states
//   - wt_store_chunk_t  : one naturally aligned chunk {be, offset, size}
//   - next_chunk64()    : greedy selection of the next aligned chunk
package wt_l15_store_splitter_pkg;

  localparam int unsigned MEM_TID_WIDTH = 2;

  // L1.5 size encoding
  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  typedef struct packed {
    logic [7:0] be;
    logic [2:0] offset;
    logic [1:0] size;
  } wt_store_chunk_t;

  // Largest naturally aligned chunk starting at the lowest set byte lane.
  // An all-zero byte enable yields an all-zero chunk.
  function automatic wt_store_chunk_t next_chunk64(input logic [7:0] be);
    wt_store_chunk_t res;
    logic [2:0]      idx;
    logic [7:0]      sh;
    res = '0;
    idx = 3'd0;
    // Scan downwards so the last hit is the lowest set bit.
    for (int k = 7; k >= 0; k--) begin
      if (be[k]) idx = 3'(k);
    end
    sh = be >> idx;
    if (be == 8'hFF) begin
      res.be     = 8'hFF;
      res.offset = 3'd0;
      res.size   = SIZE_DWORD;
    end else if (be != 8'h00) begin
      res.offset = idx;
      if (idx[1:0] == 2'b00 && sh[3:0] == 4'hF) begin
        res.be   = 8'h0F << idx;
        res.size = SIZE_WORD;
      end else if (idx[0] == 1'b0 && sh[1:0] == 2'b11) begin
        res.be   = 8'h03 << idx;
        res.size = SIZE_HWORD;
      end else begin
        res.be   = 8'h01 << idx;
        res.size = SIZE_BYTE;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wt_l15_store_splitter_chunk_sel.sv
// Purely combinational chunk selector: wraps next_chunk64 so it can be
// reused and checked on its own.
//   rem_be : remaining byte enable of the store
//   chunk  : next aligned chunk {be, offset, size}
module wt_l15_store_splitter_chunk_sel
  import wt_l15_store_splitter_pkg::*;
(
  input  logic [7:0]      rem_be,
  output wt_store_chunk_t chunk
);

  assign chunk = next_chunk64(rem_be);

endmodule

// File: rtl/wt_l15_store_splitter.sv
// Splits one 64-bit store with an arbitrary byte enable into the minimal
// ascending sequence of naturally aligned chunks for the L1.5 adapter.
// Handshake (both sides): a transfer happens in any cycle where valid and
// ready are both high; valid never waits for ready, and the payload holds
// stable while valid is high and ready is low.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   req_*              : store request from the write buffer
//   l15_*              : chunk stream to the L1.5 adapter
//   busy_o             : FSM is in SPLIT (state debug view)
module wt_l15_store_splitter
  import wt_l15_store_splitter_pkg::*;
#(
  parameter int unsigned PLEN  = 56,
  parameter int unsigned TID_W = MEM_TID_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_paddr_i,
  input  logic [63:0]      req_data_i,
  input  logic [7:0]       req_be_i,
  input  logic [TID_W-1:0] req_tid_i,
  output logic             l15_valid_o,
  input  logic             l15_ready_i,
  output logic [PLEN-1:0]  l15_paddr_o,
  output logic [63:0]      l15_data_o,
  output logic [7:0]       l15_be_o,
  output logic [1:0]       l15_size_o,
  output logic [TID_W-1:0] l15_tid_o,
  output logic             l15_last_o,
  output logic             busy_o
);

  split_state_e      state_q, state_d;
  logic [PLEN-4:0]   paddr_q;
  logic [63:0]       data_q;
  logic [TID_W-1:0]  tid_q;
  logic [7:0]        rem_be_q;

  wt_store_chunk_t   chunk;
  logic [7:0]        rem_be_next;
  logic              in_split;
  logic              last;
  logic              accept;

  // Byte lane within the dword comes from the chunk offset instead.
  logic              unused_paddr_lsb;
  assign unused_paddr_lsb = ^req_paddr_i[2:0];

  wt_l15_store_splitter_chunk_sel u_chunk_sel (
    .rem_be (rem_be_q),
    .chunk  (chunk)
  );

  assign in_split    = (state_q == ST_SPLIT);
  assign rem_be_next = rem_be_q & ~chunk.be;
  assign last        = in_split && (rem_be_next == 8'h00);

  // Ready in IDLE, or when the final chunk is leaving this cycle so the
  // next store can load without a bubble.
  assign req_ready_o = !in_split || (l15_ready_i && last);
  // Zero-byte-enable requests are consumed but never loaded.
  assign accept      = req_valid_i && req_ready_o && (req_be_i != 8'h00);

  assign l15_valid_o = in_split;
  assign l15_be_o    = in_split ? chunk.be   : 8'h00;
  assign l15_size_o  = in_split ? chunk.size : 2'b00;
  assign l15_last_o  = last;
  assign l15_paddr_o = {paddr_q, (in_split ? chunk.offset : 3'b000)};
  assign l15_data_o  = data_q;
  assign l15_tid_o   = tid_q;
  assign busy_o      = in_split;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SPLIT;
      end
      ST_SPLIT: begin
        if (l15_ready_i && last) state_d = accept ? ST_SPLIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      data_q   <= '0;
      tid_q    <= '0;
      rem_be_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        paddr_q  <= req_paddr_i[PLEN-1:3];
        data_q   <= req_data_i;
        tid_q    <= req_tid_i;
        rem_be_q <= req_be_i;
      end else if (in_split && l15_ready_i) begin
        rem_be_q <= rem_be_next;
      end
    end
  end

endmodule

// File: tb/tb_wt_l15_store_splitter.sv
module tb_wt_l15_store_splitter;
  import wt_l15_store_splitter_pkg::*;

  localparam int unsigned PLEN  = 56;
  localparam int unsigned TID_W = MEM_TID_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             req_valid;
  logic             req_ready;
  logic [PLEN-1:0]  req_paddr;
  logic [63:0]      req_data;
  logic [7:0]       req_be;
  logic [TID_W-1:0] req_tid;
  logic             l15_valid;
  logic             l15_ready;
  logic [PLEN-1:0]  l15_paddr;
  logic [63:0]      l15_data;
  logic [7:0]       l15_be;
  logic [1:0]       l15_size;
  logic [TID_W-1:0] l15_tid;
  logic             l15_last;
  logic             busy;

  int total = 0;
  int bad   = 0;

  wt_l15_store_splitter #(.PLEN(PLEN), .TID_W(TID_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_paddr_i (req_paddr),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .req_tid_i   (req_tid),
    .l15_valid_o (l15_valid),
    .l15_ready_i (l15_ready),
    .l15_paddr_o (l15_paddr),
    .l15_data_o  (l15_data),
    .l15_be_o    (l15_be),
    .l15_size_o  (l15_size),
    .l15_tid_o   (l15_tid),
    .l15_last_o  (l15_last),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the chunk currently presented (valid, be, size, paddr, last, tid).
  task automatic chk_chunk(input string tag, input logic [7:0] be, input logic [1:0] size,
                           input logic [PLEN-1:0] paddr, input logic last,
                           input logic [TID_W-1:0] tid);
    chk({tag, ".valid"}, 64'(l15_valid), 64'd1);
    chk({tag, ".be"},    64'(l15_be),    64'(be));
    chk({tag, ".size"},  64'(l15_size),  64'(size));
    chk({tag, ".paddr"}, 64'(l15_paddr), 64'(paddr));
    chk({tag, ".last"},  64'(l15_last),  64'(last));
    chk({tag, ".tid"},   64'(l15_tid),   64'(tid));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [PLEN-1:0] paddr, input logic [7:0] be,
                           input logic [TID_W-1:0] tid, input logic [63:0] data);
    req_valid = 1'b1;
    req_paddr = paddr;
    req_be    = be;
    req_tid   = tid;
    req_data  = data;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(l15_valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),      64'd0);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    chk({tag, ".be"},    64'(l15_be),    64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_paddr = '0;
    req_data  = '0;
    req_be    = '0;
    req_tid   = '0;
    l15_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset.size", 64'(l15_size), 64'd0);
    chk("reset.last", 64'(l15_last), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full dword
    l15_ready = 1'b1;
    drive_req(56'h1000, 8'hFF, 2'd1, 64'h1122_3344_5566_7788);
    #1 chk("ff.accept_ready", 64'(req_ready), 64'd1);
    chk("ff.no_valid_yet", 64'(l15_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    #1 chk_chunk("ff.c0", 8'hFF, 2'b11, 56'h1000, 1'b1, 2'd1);
    chk("ff.req_ready_last", 64'(req_ready), 64'd1);
    chk("ff.data", l15_data, 64'h1122_3344_5566_7788);
    chk("ff.busy", 64'(busy), 64'd1);
    tick();
    #1 chk_idle("ff.after");

    // be=7E at 0x2008: byte, hword, hword, byte
    drive_req(56'h2008, 8'h7E, 2'd2, 64'hA5A5_5A5A_0F0F_F0F0);
    tick();
    req_valid = 1'b0;
    #1 chk_chunk("7e.c0", 8'h02, 2'b00, 56'h2009, 1'b0, 2'd2);
    chk("7e.c0.req_ready", 64'(req_ready), 64'd0);
    tick();
    #1 chk_chunk("7e.c1", 8'h0C, 2'b01, 56'h200A, 1'b0, 2'd2);
    tick();
    #1 chk_chunk("7e.c2", 8'h30, 2'b01, 56'h200C, 1'b0, 2'd2);
    tick();
    #1 chk_chunk("7e.c3", 8'h40, 2'b00, 56'h200E, 1'b1, 2'd2);
    tick();
    #1 chk_idle("7e.after");

    // be=55 with ready toggling: outputs hold during the stall
    l15_ready = 1'b0;
    drive_req(56'h3000, 8'h55, 2'd3, 64'h0);
    tick();
    req_valid = 1'b0;
    #1 chk_chunk("55.c0.stall", 8'h01, 2'b00, 56'h3000, 1'b0, 2'd3);
    tick();
    #1 chk_chunk("55.c0.hold", 8'h01, 2'b00, 56'h3000, 1'b0, 2'd3);
    l15_ready = 1'b1;
    tick();
    l15_ready = 1'b0;
    #1 chk_chunk("55.c1.stall", 8'h04, 2'b00, 56'h3002, 1'b0, 2'd3);
    tick();
    #1 chk_chunk("55.c1.hold", 8'h04, 2'b00, 56'h3002, 1'b0, 2'd3);
    l15_ready = 1'b1;
    tick();
    l15_ready = 1'b0;
    #1 chk_chunk("55.c2.stall", 8'h10, 2'b00, 56'h3004, 1'b0, 2'd3);
    tick();
    l15_ready = 1'b1;
    tick();
    l15_ready = 1'b0;
    #1 chk_chunk("55.c3.stall", 8'h40, 2'b00, 56'h3006, 1'b1, 2'd3);
    chk("55.c3.ready_stalled", 64'(req_ready), 64'd0);
    tick();
    #1 chk("55.c3.busy_hold", 64'(busy), 64'd1);
    l15_ready = 1'b1;
    #1 chk("55.c3.ready_now", 64'(req_ready), 64'd1);
    tick();
    #1 chk_idle("55.after");

    // Back-to-back: F0 then 03 with no gap
    drive_req(56'h4000, 8'hF0, 2'd1, 64'h0);
    tick();
    drive_req(56'h5000, 8'h03, 2'd3, 64'hDEAD_BEEF_0000_0001);
    #1 chk_chunk("b2b.f0", 8'hF0, 2'b10, 56'h4004, 1'b1, 2'd1);
    chk("b2b.ready_same_cycle", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    #1 chk_chunk("b2b.03", 8'h03, 2'b01, 56'h5000, 1'b1, 2'd3);
    chk("b2b.data", l15_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    #1 chk_idle("b2b.after");

    // Zero byte enable: consumed, nothing emitted
    drive_req(56'h7000, 8'h00, 2'd2, 64'h0);
    #1 chk("be0.ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    #1 chk_idle("be0.after");
    tick();
    #1 chk("be0.still_idle", 64'(l15_valid), 64'd0);

    // Reset after the first chunk of be=AA
    drive_req(56'h6000, 8'hAA, 2'd1, 64'h0);
    tick();
    req_valid = 1'b0;
    #1 chk_chunk("aa.c0", 8'h02, 2'b00, 56'h6001, 1'b0, 2'd1);
    tick();
    rst_n = 1'b0;
    #1 chk_chunk("aa.c1", 8'h08, 2'b00, 56'h6003, 1'b0, 2'd1);
    tick();
    #1 chk_idle("aa.reset");
    rst_n = 1'b1;
    tick();
    #1 chk_idle("aa.post1");
    tick();
    #1 chk_idle("aa.post2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
